// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
//   Hardware return-address stack that feeds DoST to the program counter.
//   CALL pushes PCin+1, interrupt entry pushes PCin and tags the entry as an
//   ISR frame, and Ret pops. All state changes on posedge CLK, so DoST is
//   stable before the PC samples it on the following negedge.
//
// Ports
//   CLK       in   1      clock, state updates on posedge
//   RST       in   1      asynchronous, active-high reset
//   Push      in   1      CALL: push PCin+1 (untagged)
//   IntPush   in   1      interrupt entry: push PCin (tagged); wins over Push
//   Ret       in   1      pop top entry
//   PCin      in   AW     current PC value
//   ErrClr    in   1      clears sticky Overflow/Underflow
//   DoST      out  AW     top-of-stack address, 0 when empty
//   Depth     out  PW+1   number of valid entries, 0..DEPTH
//   Full      out  1      Depth == DEPTH
//   Empty     out  1      Depth == 0
//   InISR     out  1      at least one tagged frame is on the stack
//   IsrRet    out  1      one-cycle pulse after a tagged frame is popped
//   Overflow  out  1      sticky: push attempted while Full
//   Underflow out  1      sticky: Ret attempted while Empty
// ---------------------------------------------------------------------------
module ret_addr_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 16,
  parameter int PW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Push,
  input  logic          IntPush,
  input  logic          Ret,
  input  logic [AW-1:0] PCin,
  input  logic          ErrClr,
  output logic [AW-1:0] DoST,
  output logic [PW:0]   Depth,
  output logic          Full,
  output logic          Empty,
  output logic          InISR,
  output logic          IsrRet,
  output logic          Overflow,
  output logic          Underflow
);

  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  // Storage: each entry holds {tag, addr}; contents are not reset.
  logic [AW-1:0] r_mem_addr [DEPTH];
  logic          r_mem_tag  [DEPTH];

  logic [PW:0]   r_sp;
  logic [PW:0]   r_isr_cnt;
  logic          r_ovf;
  logic          r_udf;
  logic          r_isr_ret;

  logic          w_any_push;
  logic          w_new_tag;
  logic [AW-1:0] w_new_addr;
  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_top_idx;
  logic          w_top_tag;

  logic          w_wr_en;
  logic [PW-1:0] w_wr_idx;
  logic [PW:0]   w_sp_nxt;
  logic [PW:0]   w_isr_nxt;
  logic          w_isr_ret_nxt;
  logic          w_ovf_set;
  logic          w_udf_set;

  assign w_any_push = Push | IntPush;
  assign w_new_tag  = IntPush;
  // Interrupt entry resumes at the interrupted PC; CALL resumes after it.
  assign w_new_addr = IntPush ? PCin : (PCin + {{(AW-1){1'b0}}, 1'b1});
  assign w_empty    = (r_sp == {(PW+1){1'b0}});
  assign w_full     = (r_sp == DEPTH_C);
  // Low bits of sp minus one: when sp==DEPTH the low bits are 0 and wrap to DEPTH-1.
  assign w_top_idx  = r_sp[PW-1:0] - {{(PW-1){1'b0}}, 1'b1};
  assign w_top_tag  = r_mem_tag[w_top_idx];

  assign DoST      = w_empty ? {AW{1'b0}} : r_mem_addr[w_top_idx];
  assign Depth     = r_sp;
  assign Full      = w_full;
  assign Empty     = w_empty;
  assign InISR     = (r_isr_cnt != {(PW+1){1'b0}});
  assign IsrRet    = r_isr_ret;
  assign Overflow  = r_ovf;
  assign Underflow = r_udf;

  // Next-state decode for pointer, ISR nesting count, pulse and error events.
  always_comb begin
    w_wr_en       = 1'b0;
    w_wr_idx      = r_sp[PW-1:0];
    w_sp_nxt      = r_sp;
    w_isr_nxt     = r_isr_cnt;
    w_isr_ret_nxt = 1'b0;
    w_ovf_set     = 1'b0;
    w_udf_set     = 1'b0;
    if (Ret && !w_empty) begin
      w_isr_ret_nxt = w_top_tag;
      if (w_any_push) begin
        // Pop and push together: overwrite the top entry in place.
        w_wr_en   = 1'b1;
        w_wr_idx  = w_top_idx;
        w_isr_nxt = r_isr_cnt - {{PW{1'b0}}, w_top_tag} + {{PW{1'b0}}, w_new_tag};
      end else begin
        w_sp_nxt  = r_sp - {{PW{1'b0}}, 1'b1};
        w_isr_nxt = r_isr_cnt - {{PW{1'b0}}, w_top_tag};
      end
    end else if (Ret) begin
      // Ret on an empty stack: flag it, then any push proceeds normally.
      w_udf_set = 1'b1;
      if (w_any_push) begin
        w_wr_en   = 1'b1;
        w_wr_idx  = {PW{1'b0}};
        w_sp_nxt  = {{PW{1'b0}}, 1'b1};
        w_isr_nxt = {{PW{1'b0}}, w_new_tag};
      end else begin
        w_sp_nxt  = r_sp;
      end
    end else if (w_any_push) begin
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_sp_nxt = r_sp + {{PW{1'b0}}, 1'b1};
        if (w_new_tag && (r_isr_cnt != DEPTH_C)) begin
          w_isr_nxt = r_isr_cnt + {{PW{1'b0}}, 1'b1};
        end else begin
          w_isr_nxt = r_isr_cnt;
        end
      end
    end else begin
      w_sp_nxt = r_sp;
    end
  end

  // Stack memory write; no reset since contents above sp are never observed.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem_addr[w_wr_idx] <= w_new_addr;
      r_mem_tag[w_wr_idx]  <= w_new_tag;
    end
  end

  // Control registers with asynchronous reset; a new error beats ErrClr.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sp      <= {(PW+1){1'b0}};
      r_isr_cnt <= {(PW+1){1'b0}};
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_isr_ret <= 1'b0;
    end else begin
      r_sp      <= w_sp_nxt;
      r_isr_cnt <= w_isr_nxt;
      r_ovf     <= w_ovf_set | (r_ovf & ~ErrClr);
      r_udf     <= w_udf_set | (r_udf & ~ErrClr);
      r_isr_ret <= w_isr_ret_nxt;
    end
  end

endmodule
